// File: rtl/kernel_stream_sink_pkg.sv
// kernel_stream_sink_pkg
//  Shared definitions for the kernel output stream sink: default widths,
//  FSM state encoding and a small state-decode helper.
package kernel_stream_sink_pkg;

  localparam int DEF_STREAMW = 34;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_CNTW    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A run is in progress while words are still expected or still buffered.
  function automatic logic state_is_busy(state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/kernel_stream_sink_fifo.sv
// kernel_stream_sink_fifo
//  Synchronous first-word-fall-through FIFO with asynchronous reset.
//  Ports:
//   clk, rst        clock, async active-high reset (empties the FIFO)
//   push, wr_data   write wr_data at the edge where push is high (ignored when full)
//   pop             remove head at the edge where pop is high (ignored when empty)
//   rd_valid        head is valid (FIFO not empty)
//   rd_data         head word, zero while empty
//   fill            number of words currently stored (0..DEPTH)
module kernel_stream_sink_fifo
  import kernel_stream_sink_pkg::*;
#(
  parameter int W     = DEF_STREAMW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic                     rd_valid,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  // Pointers carry one extra bit so full and empty are distinguishable:
  // equal pointers mean empty, equal index with differing MSB means full.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         empty;
  logic         full;
  logic         do_push;
  logic         do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign fill     = wr_ptr - rd_ptr;
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  // Storage needs no reset: rd_data is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/kernel_stream_sink.sv
// kernel_stream_sink
//  Consumer end of the kernel output stream. Drives a registered oready,
//  buffers accepted out1_s0 words in a FWFT FIFO and counts a programmed
//  number of words per run, raising done once all of them have been read out.
//  Ports:
//   clk, rst            clock, async active-high reset
//   ovalid, out1_s0     kernel output word; accepted at edges where ovalid & oready
//   oready              registered ready to the kernel
//   start, n_words      1-cycle run start and word count (taken in IDLE/DONE only)
//   rd_valid, rd_data   FIFO head (FWFT); rd_data is zero while empty
//   rd_ready            head popped at edges where rd_valid & rd_ready
//   rx_count            words accepted this run
//   busy, done          run in progress / run complete (level)
//   state_dbg           current FSM state encoding
//  Handshakes: a transfer happens on exactly the rising edge where valid and
//  ready are both high; neither side may rely on the other's same-cycle value
//  beyond that, and ovalid without oready transfers nothing.
module kernel_stream_sink
  import kernel_stream_sink_pkg::*;
#(
  parameter int STREAMW = DEF_STREAMW,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CNTW    = DEF_CNTW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ovalid,
  input  logic [STREAMW-1:0] out1_s0,
  output logic               oready,
  input  logic               start,
  input  logic [CNTW-1:0]    n_words,
  output logic               rd_valid,
  output logic [STREAMW-1:0] rd_data,
  input  logic               rd_ready,
  output logic [CNTW-1:0]    rx_count,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FONE    = (AW+1)'(1);
  localparam logic [AW:0]   DEPTH_F = (AW+1)'(DEPTH);
  localparam logic [CNTW-1:0] CONE  = CNTW'(1);

  state_t          state;
  state_t          state_next;
  logic            push;
  logic            pop;
  logic            start_ok;
  logic [AW:0]     fill;
  logic [AW:0]     fill_next;
  logic [CNTW-1:0] n_lat;
  logic [CNTW-1:0] n_lat_next;
  logic [CNTW-1:0] rx_count_next;
  logic            oready_next;

  assign push     = ovalid && oready;
  assign pop      = rd_valid && rd_ready;
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

  assign fill_next     = fill + (push ? FONE : '0) - (pop ? FONE : '0);
  assign rx_count_next = start_ok ? '0 : (push ? rx_count + CONE : rx_count);
  assign n_lat_next    = start_ok ? n_words : n_lat;

  // oready is computed from next-cycle values so it is already low on the
  // cycle the FIFO becomes full or the last expected word has arrived.
  assign oready_next = (state_next == ST_RUN) && (fill_next < DEPTH_F)
                       && (rx_count_next < n_lat_next);

  kernel_stream_sink_fifo #(
    .W     (STREAMW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wr_data  (out1_s0),
    .pop      (pop),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .fill     (fill)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = (n_words == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (push && (rx_count_next == n_lat)) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fill_next == '0) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = state_is_busy(state);
    done      = (state == ST_DONE);
    state_dbg = state;
  end

  // Run counters and the ready register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_lat    <= '0;
      rx_count <= '0;
      oready   <= 1'b0;
    end else begin
      n_lat    <= n_lat_next;
      rx_count <= rx_count_next;
      oready   <= oready_next;
    end
  end

endmodule
